// File: rtl/vedic_column_mult.sv
// Sequential WxW unsigned multiplier, Urdhva-Tiryagbhyam style: one anti-diagonal
// column of AND partial products is summed with the running carry per clock.
module vedic_column_mult #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product,
    output logic             busy
);

    localparam int SW = $clog2(2*W+1);
    localparam int CW = $clog2(W+1);
    localparam int KW = $clog2(2*W);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COLUMN = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           state_q;
    logic [KW-1:0]    col_q;
    logic [CW-1:0]    carry_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [2*W-1:0]   product_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [SW-1:0]    col_sum_d;
    logic [CW-1:0]    carry_d;
    logic             last_col_s;

    // Column sum: carry plus every a[i]&b[j] on the anti-diagonal i+j == col.
    always_comb begin
        col_sum_d = SW'(carry_q);
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                if (KW'(i + j) == col_q) begin
                    col_sum_d = col_sum_d + SW'(a_q[i] & b_q[j]);
                end else begin
                    col_sum_d = col_sum_d;
                end
            end
        end
        carry_d    = CW'(col_sum_d >> 1);
        last_col_s = (col_q == KW'(2*W-2));
    end

    // Control FSM with registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            carry_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q       <= a;
                        b_q       <= b;
                        carry_q   <= '0;
                        product_q <= '0;
                        col_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_COLUMN;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_COLUMN: begin
                    product_q[col_q] <= col_sum_d[0];
                    carry_q          <= carry_d;
                    col_q            <= col_q + KW'(1);
                    // The final column also retires the top bit from the leftover carry.
                    if (last_col_s) begin
                        product_q[2*W-1] <= carry_d[0];
                        busy_q           <= 1'b0;
                        out_valid_q      <= 1'b1;
                        state_q          <= S_DONE;
                    end else begin
                        state_q          <= S_COLUMN;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q     <= S_DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_vedic_column_mult.sv
// Directed bench for vedic_column_mult at W=8: reset, products, latency,
// backpressure, mid-operation reset and back-to-back throughput.
module tb_vedic_column_mult;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int accept_cyc = 0;

    vedic_column_mult #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One full operation; returns observed latency, product and busy cycles.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input int stall,
                          output int lat, output logic [15:0] prod, output int busy_cnt);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
        end
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_v;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb_v;
        lat      = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        prod = product;
        if (stall > 0) begin
            repeat (stall) begin @(posedge clk); #1; end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'd0; b = 8'd0;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (product !== 16'h0000) begin n_err++; $display("FAIL reset_product: got %h want 0000", product); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [15:0] p;
        run_op(8'd13, 8'd11, 0, lat, p, bc);
        n_cmp++; if (lat !== 15) begin n_err++; $display("FAIL basic_latency: got %0d want 15", lat); end
        n_cmp++; if (p !== 16'h008F) begin n_err++; $display("FAIL basic_product: got %h want 008f", p); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_out_valid_drop: got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready_back: got %0b want 1", in_ready); end
        n_cmp++; if (product !== 16'h008F) begin n_err++; $display("FAIL basic_product_hold: got %h want 008f", product); end
    endtask

    task automatic test_max();
        int lat, bc;
        logic [15:0] p;
        logic [2:0] hi;
        in_valid = 1'b1; a = 8'd255; b = 8'd255; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        hi = dut.carry_q[3:1];
        n_cmp++; if (hi !== 3'b000) begin n_err++; $display("FAIL max_carry_upper: got %b want 000", hi); end
        n_cmp++; if (lat !== 15) begin n_err++; $display("FAIL max_latency: got %0d want 15", lat); end
        n_cmp++; if (product !== 16'hFE01) begin n_err++; $display("FAIL max_product: got %h want fe01", product); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        run_op(8'd128, 8'd2, 0, lat, p, bc);
        n_cmp++; if (p !== 16'h0100) begin n_err++; $display("FAIL shift_product: got %h want 0100", p); end
    endtask

    task automatic test_zero();
        int lat, bc;
        logic [15:0] p;
        run_op(8'd0, 8'hA5, 0, lat, p, bc);
        n_cmp++; if (p !== 16'h0000) begin n_err++; $display("FAIL zero_product: got %h want 0000", p); end
        n_cmp++; if (lat !== 15) begin n_err++; $display("FAIL zero_latency: got %0d want 15", lat); end
        n_cmp++; if (bc !== 15) begin n_err++; $display("FAIL zero_busy_cycles: got %0d want 15", bc); end
    endtask

    task automatic test_backpressure();
        int lat;
        in_valid = 1'b1; a = 8'd200; b = 8'd3; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat !== 15) begin n_err++; $display("FAIL bp_latency: got %0d want 15", lat); end
        in_valid = 1'b1; a = 8'd1; b = 8'd1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d]: got %0b want 1", i, out_valid); end
            n_cmp++; if (product !== 16'h0258) begin n_err++; $display("FAIL bp_product[%0d]: got %h want 0258", i, product); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_handshake: got %0b want 0", out_valid); end
        n_cmp++; if (product !== 16'h0258) begin n_err++; $display("FAIL bp_product_keep: got %h want 0258", product); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_no_accept: busy got %0b want 0", busy); end
    endtask

    task automatic test_reset_midop();
        int lat, bc;
        logic [15:0] p;
        in_valid = 1'b1; a = 8'd99; b = 8'd77; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (product !== 16'h0000) begin n_err++; $display("FAIL midrst_product: got %h want 0000", product); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %0b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready_low: got %0b want 0", in_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_no_valid[%0d]: got %0b want 0", i, out_valid); end
        end
        run_op(8'd7, 8'd6, 0, lat, p, bc);
        n_cmp++; if (p !== 16'h002A) begin n_err++; $display("FAIL midrst_next_product: got %h want 002a", p); end
        n_cmp++; if (lat !== 15) begin n_err++; $display("FAIL midrst_next_latency: got %0d want 15", lat); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [4] = '{8'd100, 8'd1, 8'd17, 8'd250};
        logic [7:0]  vb [4] = '{8'd100, 8'd255, 8'd15, 8'd4};
        logic [15:0] ve [4] = '{16'h2710, 16'h00FF, 16'h00FF, 16'h03E8};
        int lat, bc, prev;
        logic [15:0] p;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], 0, lat, p, bc);
            n_cmp++; if (p !== ve[i]) begin n_err++; $display("FAIL b2b_product[%0d]: got %h want %h", i, p, ve[i]); end
            if (prev >= 0) begin
                n_cmp++; if (accept_cyc - prev !== 17) begin n_err++; $display("FAIL b2b_interval[%0d]: got %0d want 17", i, accept_cyc - prev); end
            end
            prev = accept_cyc;
        end
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            int st;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            st = int'($urandom_range(0, 3));
            run_op(ra, rb, st, lat, p, bc);
            n_cmp++; if (p !== 16'(ra) * 16'(rb)) begin n_err++; $display("FAIL rand_product[%0d]: %0d*%0d got %0d want %0d", i, ra, rb, p, 16'(ra) * 16'(rb)); end
            n_cmp++; if (lat !== 15) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want 15", i, lat); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
